// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel word to serial bit stream for the sequence detector.
// One holding word plus a shift register lets back-to-back words stream gap-free.
module seq_bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             serial_out,
    output logic             serial_active,
    output logic             frame_start
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d, shift_q, shift_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             out_q, out_d, act_q, act_d, fs_q, fs_d;
    logic             accept, last, load, busy;
    logic [WIDTH-1:0] src, rest;
    logic             head;

    always_comb begin
        accept      = din_valid && !hold_full_q;
        last        = (state_q == SHIFT) && (bit_cnt_q == CW'(WIDTH - 1));
        load        = hold_full_q && ((state_q == IDLE) || last);
        busy        = (state_q == SHIFT) && !last;
        // head is the bit to put on the line next; rest is what remains to shift
        src         = load ? hold_q : shift_q;
        head        = MSB_FIRST ? src[WIDTH-1] : src[0];
        rest        = MSB_FIRST ? {src[WIDTH-2:0], 1'b0} : {1'b0, src[WIDTH-1:1]};
        hold_d      = accept ? din : hold_q;
        hold_full_d = load ? 1'b0 : (accept || hold_full_q);
        state_d     = load ? SHIFT : (last ? IDLE : state_q);
        bit_cnt_d   = load ? '0 : (busy ? bit_cnt_q + CW'(1) : '0);
        shift_d     = (load || busy) ? rest : shift_q;
        out_d       = (load || busy) ? head : IDLE_BIT;
        act_d       = load || busy;
        fs_d        = load;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            out_q       <= IDLE_BIT;
            act_q       <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            out_q       <= out_d;
            act_q       <= act_d;
            fs_q        <= fs_d;
        end
    end

    assign din_ready     = !hold_full_q;
    assign serial_out    = out_q;
    assign serial_active = act_q;
    assign frame_start   = fs_q;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed and randomized checks of an MSB-first and an LSB-first serializer.
module tb_seq_bit_serializer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din [2];
    logic       din_valid [2];
    logic       din_ready [2];
    logic       serial_out [2];
    logic       serial_active [2];
    logic       frame_start [2];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .reset(reset), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .serial_out(serial_out[0]),
        .serial_active(serial_active[0]), .frame_start(frame_start[0])
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .serial_out(serial_out[1]),
        .serial_active(serial_active[1]), .frame_start(frame_start[1])
    );

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (serial_out[d] !== 1'b0 || serial_active[d] !== 1'b0 || frame_start[d] !== 1'b0 || din_ready[d] !== 1'b1) begin
                fails++;
                $display("FAIL reset_async[%0d]: out=%b act=%b fs=%b rdy=%b want 0 0 0 1", d, serial_out[d], serial_active[d], frame_start[d], din_ready[d]);
            end
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (serial_out[0] !== 1'b0 || serial_active[0] !== 1'b0 || din_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: out=%b act=%b rdy=%b want 0 0 1", serial_out[0], serial_active[0], din_ready[0]);
        end
    endtask

    task automatic test_single();
        logic [7:0] w = 8'h99;
        din[0] = w;
        din_valid[0] = 1'b1;
        @(posedge clk);
        #1 din_valid[0] = 1'b0;
        tests++;
        if (din_ready[0] !== 1'b0 || serial_active[0] !== 1'b0) begin
            fails++;
            $display("FAIL single_accept: rdy=%b act=%b want 0 0", din_ready[0], serial_active[0]);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            tests++;
            if (serial_out[0] !== w[7-k] || serial_active[0] !== 1'b1 || frame_start[0] !== (k == 0)) begin
                fails++;
                $display("FAIL single_bit%0d: out=%b act=%b fs=%b want %b 1 %b", k, serial_out[0], serial_active[0], frame_start[0], w[7-k], k == 0);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (serial_out[0] !== 1'b0 || serial_active[0] !== 1'b0 || frame_start[0] !== 1'b0) begin
            fails++;
            $display("FAIL single_end: out=%b act=%b fs=%b want 0 0 0", serial_out[0], serial_active[0], frame_start[0]);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] s = 16'h990F;
        din[0] = 8'h99;
        din_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (din_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ready_low: rdy=%b want 0", din_ready[0]);
        end
        din[0] = 8'h0F;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (k < 2) begin
                tests++;
                if (din_ready[0] !== (k == 0)) begin
                    fails++;
                    $display("FAIL b2b_ready%0d: rdy=%b want %b", k, din_ready[0], k == 0);
                end
            end
            if (k == 1) din_valid[0] = 1'b0;
            tests++;
            if (serial_out[0] !== s[15-k] || serial_active[0] !== 1'b1 || frame_start[0] !== (k % 8 == 0)) begin
                fails++;
                $display("FAIL b2b_bit%0d: out=%b act=%b fs=%b want %b 1 %b", k, serial_out[0], serial_active[0], frame_start[0], s[15-k], k % 8 == 0);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (serial_active[0] !== 1'b0 || serial_out[0] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: act=%b out=%b want 0 0", serial_active[0], serial_out[0]);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_lsb();
        logic [7:0] w = 8'h01;
        din[1] = w;
        din_valid[1] = 1'b1;
        @(posedge clk);
        #1 din_valid[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            tests++;
            if (serial_out[1] !== w[k] || serial_active[1] !== 1'b1 || frame_start[1] !== (k == 0)) begin
                fails++;
                $display("FAIL lsb_bit%0d: out=%b act=%b fs=%b want %b 1 %b", k, serial_out[1], serial_active[1], frame_start[1], w[k], k == 0);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (serial_active[1] !== 1'b0 || serial_out[1] !== 1'b0) begin
            fails++;
            $display("FAIL lsb_end: act=%b out=%b want 0 0", serial_active[1], serial_out[1]);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [23:0] s = 24'h00A53C;
        din[0] = 8'h00;
        din_valid[0] = 1'b1;
        @(posedge clk);
        #1 din[0] = 8'hA5;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            tests++;
            if (din_ready[0] !== (k == 0 || k == 8 || k >= 16)) begin
                fails++;
                $display("FAIL stall_ready%0d: rdy=%b want %b", k, din_ready[0], k == 0 || k == 8 || k >= 16);
            end
            if (k == 1) din[0] = 8'h3C;
            if (k == 9) din_valid[0] = 1'b0;
            tests++;
            if (serial_out[0] !== s[23-k] || serial_active[0] !== 1'b1 || frame_start[0] !== (k % 8 == 0)) begin
                fails++;
                $display("FAIL stall_bit%0d: out=%b act=%b fs=%b want %b 1 %b", k, serial_out[0], serial_active[0], frame_start[0], s[23-k], k % 8 == 0);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        logic [7:0] w = 8'h90;
        din[0] = 8'hFF;
        din_valid[0] = 1'b1;
        @(posedge clk);
        #1 din_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        tests++;
        if (serial_out[0] !== 1'b0 || serial_active[0] !== 1'b0 || frame_start[0] !== 1'b0 || din_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL midreset_async: out=%b act=%b fs=%b rdy=%b want 0 0 0 1", serial_out[0], serial_active[0], frame_start[0], din_ready[0]);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        din[0] = w;
        din_valid[0] = 1'b1;
        @(posedge clk);
        #1 din_valid[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            tests++;
            if (serial_out[0] !== w[7-k] || serial_active[0] !== 1'b1 || frame_start[0] !== (k == 0)) begin
                fails++;
                $display("FAIL midreset_bit%0d: out=%b act=%b fs=%b want %b 1 %b", k, serial_out[0], serial_active[0], frame_start[0], w[7-k], k == 0);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (serial_active[0] !== 1'b0 || serial_out[0] !== 1'b0) begin
            fails++;
            $display("FAIL midreset_end: act=%b out=%b want 0 0", serial_active[0], serial_out[0]);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Model: a word accepted at cycle c occupies cycles max(c+1, previous end+1) .. +7 on the line.
    task automatic test_random();
        logic eb [int];
        bit   ef [int];
        int   prev_end [2];
        int   pend_start [2];
        bit   exp_rdy [2];
        int   cyc = 0;
        int   key, start;
        logic [7:0] w;
        prev_end = '{-1, -1};
        pend_start = '{-1, -1};
        repeat (400) begin
            for (int d = 0; d < 2; d++) begin
                key = cyc * 2 + d;
                exp_rdy[d] = !(pend_start[d] > cyc);
                tests++;
                if (din_ready[d] !== exp_rdy[d]) begin
                    fails++;
                    $display("FAIL rand_ready[%0d] cyc%0d: rdy=%b want %b", d, cyc, din_ready[d], exp_rdy[d]);
                end
                tests++;
                if (eb.exists(key)) begin
                    if (serial_active[d] !== 1'b1 || serial_out[d] !== eb[key] || frame_start[d] !== ef[key]) begin
                        fails++;
                        $display("FAIL rand_bit[%0d] cyc%0d: out=%b act=%b fs=%b want %b 1 %b", d, cyc, serial_out[d], serial_active[d], frame_start[d], eb[key], ef[key]);
                    end
                end else if (serial_active[d] !== 1'b0 || serial_out[d] !== 1'b0 || frame_start[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_idle[%0d] cyc%0d: out=%b act=%b fs=%b want 0 0 0", d, cyc, serial_out[d], serial_active[d], frame_start[d]);
                end
                din_valid[d] = ($urandom_range(0, 3) != 0);
                din[d] = 8'($urandom);
            end
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (din_valid[d] && exp_rdy[d]) begin
                    w = din[d];
                    start = (cyc + 1 > prev_end[d] + 1) ? cyc + 1 : prev_end[d] + 1;
                    for (int i = 0; i < 8; i++) begin
                        eb[(start + i) * 2 + d] = (d == 0) ? w[7-i] : w[i];
                        ef[(start + i) * 2 + d] = (i == 0);
                    end
                    prev_end[d] = start + 7;
                    pend_start[d] = start;
                end
            end
            #1;
        end
        din_valid[0] = 1'b0;
        din_valid[1] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        din[0] = 8'h00;
        din[1] = 8'h00;
        din_valid[0] = 1'b0;
        din_valid[1] = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb();
        test_stall();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
